// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, HSIZE/HRESP encodings and the
// address-alignment check used by the initiator before it touches the bus.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    // Sizes wider than a word are never legal on this 32-bit fabric.
    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: is_aligned = 1'b1;
            HSIZE_HALF: is_aligned = ~addr_lo[0];
            HSIZE_WORD: is_aligned = (addr_lo == 2'b00);
            default:    is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator.
// Turns a valid/ready request into one NONSEQ single transfer followed by an
// IDLE address phase, and returns read data / error status on a valid/ready
// response channel.
//   HCLK, HRESETn              clock, async active-low reset
//   req_valid/ready/addr/write/size/wdata   request channel
//   rsp_valid/ready/rdata/err/timeout       response channel
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA        registered AHB master outputs
//   HRDATA/HREADY/HRESP                     AHB slave returns
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q,  state_d;
    htrans_t           htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q,  haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q,  hsize_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              err_q,    err_d;
    logic              tmo_q,    tmo_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic              tmo_hit;
    logic [31:0]       cnt_next;

    // The counter holds the number of wait cycles already seen; this cycle's
    // HREADY=0 would be the one that reaches the limit.
    always_comb begin
        cnt_next = 32'(cnt_q) + 32'd1;
        tmo_hit  = (TIMEOUT_CYCLES != 0) && !HREADY && (cnt_next == 32'(TIMEOUT_CYCLES));
    end

    always_comb begin
        state_d  = state_q;
        htrans_d = htrans_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!is_aligned(req_size, req_addr[1:0])) begin
                        // Rejected locally: the bus never sees this request.
                        state_d = ST_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b0;
                    end else begin
                        state_d  = ST_ADDR;
                        htrans_d = NONSEQ;
                        haddr_d  = req_addr;
                        hwrite_d = req_write;
                        hsize_d  = req_size;
                        // Loaded now; the bus is idle before the data phase
                        // so it is stable for the whole of it.
                        hwdata_d = req_wdata;
                        cnt_d    = '0;
                    end
                end
            end

            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = IDLE;
                    cnt_d    = '0;
                end else if (tmo_hit) begin
                    state_d  = ST_RESP;
                    htrans_d = IDLE;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    tmo_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                // HRESP is only meaningful on the HREADY=1 edge.
                if (HREADY) begin
                    state_d = ST_RESP;
                    err_d   = (HRESP == HRESP_ERROR);
                    rdata_d = (!hwrite_q && (HRESP != HRESP_ERROR)) ? HRDATA : '0;
                    tmo_d   = 1'b0;
                end else if (tmo_hit) begin
                    state_d  = ST_RESP;
                    htrans_d = IDLE;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    tmo_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            htrans_q <= IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_WORD;
            hwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            htrans_q <= htrans_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HSIZE  = hsize_q;
    assign HWDATA = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small AHB memory slave
// (configurable wait states, two-cycle ERROR above MEM_BYTES) and a
// scoreboard queue of expected responses.
module tb_ahb_lite_master;
    import ahb_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [2:0]  req_size = 3'd2;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // ---------------- memory slave ----------------
    logic [31:0] mem [MEM_BYTES/4];
    logic        dp_active, dp_write, dp_err;
    logic [31:0] dp_addr;
    int          dp_wait;
    int          wait_cfg = 0;
    logic        stuck = 1'b0;

    always_comb begin
        HREADY = stuck ? 1'b0 : (!dp_active || dp_wait == 0);
        HRESP  = dp_active && dp_err;
        HRDATA = 32'h0;
        if (dp_active) begin
            if (dp_err)        HRDATA = 32'hBAD0_BAD0;
            else if (dp_write) HRDATA = 32'hCAFE_F00D;
            else               HRDATA = mem[dp_addr[9:2]];
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_active <= 1'b0; dp_write <= 1'b0; dp_err <= 1'b0;
            dp_addr <= '0; dp_wait <= 0;
        end else begin
            if (dp_active) begin
                if (dp_wait > 0) dp_wait <= dp_wait - 1;
                else begin
                    if (dp_write && !dp_err) mem[dp_addr[9:2]] <= HWDATA;
                    dp_active <= 1'b0;
                end
            end
            if (HTRANS == 2'b10 && HREADY) begin
                dp_active <= 1'b1;
                dp_addr   <= HADDR;
                dp_write  <= HWRITE;
                dp_err    <= (HADDR >= MEM_BYTES);
                dp_wait   <= (HADDR >= MEM_BYTES) ? 1 : wait_cfg;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  ht1, ht2, ht_rsp;
    logic [31:0] ha1;
    logic        hw1, saw_nonseq, hw_bad;
    logic [2:0]  hs1;

    // Drive one request, wait (bounded) for its response, compare it against
    // the scoreboard, optionally hold rsp_ready low for 'hold' cycles.
    task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input logic et,
                        input int elat, input int hold);
        exp_t e, got;
        int n;
        logic [31:0] r0;
        logic e0, t0, bp_bad;
        e.rdata = er; e.err = ee; e.tmo = et; e.lat = elat;
        sb.push_back(e);
        @(negedge HCLK);
        chk({tag, ":req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = a; req_write = w; req_size = sz; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge HCLK);
        #1 req_valid = 1'b0;
        n = 0; saw_nonseq = 1'b0; hw_bad = 1'b0;
        while (n < 40) begin
            @(negedge HCLK);
            n++;
            if (n == 1) begin ht1 = HTRANS; ha1 = HADDR; hw1 = HWRITE; hs1 = HSIZE; end
            if (n == 2) ht2 = HTRANS;
            if (HTRANS == 2'b10) saw_nonseq = 1'b1;
            if (rsp_valid) break;
            if (w && n >= 2 && HWDATA !== wd) hw_bad = 1'b1;
        end
        ht_rsp = HTRANS;
        chk({tag, ":rsp_seen"}, 64'(rsp_valid), 64'd1);
        got = sb.pop_front();
        chk({tag, ":latency"}, 64'(n), 64'(got.lat));
        chk({tag, ":rdata"}, 64'(rsp_rdata), 64'(got.rdata));
        chk({tag, ":err"}, 64'(rsp_err), 64'(got.err));
        chk({tag, ":timeout"}, 64'(rsp_timeout), 64'(got.tmo));
        chk({tag, ":htrans_at_rsp"}, 64'(ht_rsp), 64'(IDLE));
        if (hold > 0) begin
            r0 = rsp_rdata; e0 = rsp_err; t0 = rsp_timeout; bp_bad = 1'b0;
            repeat (hold) begin
                @(negedge HCLK);
                if (!rsp_valid || rsp_rdata !== r0 || rsp_err !== e0 ||
                    rsp_timeout !== t0 || req_ready !== 1'b0) bp_bad = 1'b1;
            end
            chk({tag, ":backpressure_stable"}, 64'(bp_bad), 64'd0);
            rsp_ready = 1'b1;
        end
        @(posedge HCLK);
        @(negedge HCLK);
        chk({tag, ":rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":HTRANS"},      64'(HTRANS),      64'd0);
        chk({tag, ":HADDR"},       64'(HADDR),       64'd0);
        chk({tag, ":HWRITE"},      64'(HWRITE),      64'd0);
        chk({tag, ":HSIZE"},       64'(HSIZE),       64'd2);
        chk({tag, ":HWDATA"},      64'(HWDATA),      64'd0);
        chk({tag, ":rsp_valid"},   64'(rsp_valid),   64'd0);
        chk({tag, ":rsp_rdata"},   64'(rsp_rdata),   64'd0);
        chk({tag, ":rsp_err"},     64'(rsp_err),     64'd0);
        chk({tag, ":rsp_timeout"}, 64'(rsp_timeout), 64'd0);
        chk({tag, ":req_ready"},   64'(req_ready),   64'd1);
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < MEM_BYTES/4; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(negedge HCLK);
        chk_reset_vals("reset");
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Write/read round trip
        xfer("wr100", 32'h100, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 3, 0);
        chk("wr100:htrans_c1", 64'(ht1), 64'(NONSEQ));
        chk("wr100:htrans_c2", 64'(ht2), 64'(IDLE));
        chk("wr100:haddr_c1",  64'(ha1), 64'h100);
        chk("wr100:hwrite_c1", 64'(hw1), 64'd1);
        chk("wr100:hsize_c1",  64'(hs1), 64'd2);
        chk("wr100:hwdata",    64'(hw_bad), 64'd0);
        xfer("rd100", 32'h100, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 0);
        chk("rd100:htrans_c1", 64'(ht1), 64'(NONSEQ));
        chk("rd100:hwrite_c1", 64'(hw1), 64'd0);
        xfer("rd102h", 32'h102, 1'b0, 3'd1, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 0);
        chk("rd102h:hsize_c1", 64'(hs1), 64'd1);

        // Misaligned / illegal size: no bus activity, response next cycle
        xfer("mis_word", 32'h102, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        chk("mis_word:no_nonseq", 64'(saw_nonseq), 64'd0);
        xfer("mis_half", 32'h101, 1'b1, 3'd1, 32'h55, 32'h0, 1'b1, 1'b0, 1, 0);
        chk("mis_half:no_nonseq", 64'(saw_nonseq), 64'd0);
        xfer("mis_size3", 32'h100, 1'b0, 3'd3, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        chk("mis_size3:no_nonseq", 64'(saw_nonseq), 64'd0);

        // Slave ERROR (first ERROR cycle has HREADY=0 and must be ignored)
        xfer("slverr", 32'h400, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1'b0, 4, 0);

        // Data-phase wait states plus response backpressure
        wait_cfg = 3;
        xfer("wait_wr", 32'h104, 1'b1, 3'd2, 32'h12345678, 32'h0, 1'b0, 1'b0, 6, 5);
        chk("wait_wr:hwdata_stable", 64'(hw_bad), 64'd0);
        wait_cfg = 0;
        xfer("rd104", 32'h104, 1'b0, 3'd2, 32'h0, 32'h12345678, 1'b0, 1'b0, 3, 0);

        // Timeout in data phase: 16 wait cycles then an error response
        wait_cfg = 100;
        xfer("tmo_data", 32'h108, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1'b1, 18, 0);
        @(negedge HCLK); HRESETn = 1'b0;
        @(negedge HCLK); HRESETn = 1'b1;

        // Reset asserted mid data phase
        wait_cfg = 10;
        @(negedge HCLK);
        req_valid = 1'b1; req_addr = 32'h10C; req_write = 1'b1; req_size = 3'd2;
        req_wdata = 32'hA5A5_5A5A; rsp_ready = 1'b1;
        @(posedge HCLK);
        #1 req_valid = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("rst_data:hwdata_before", 64'(HWDATA), 64'hA5A5_5A5A);
        #2 HRESETn = 1'b0;
        #1 chk_reset_vals("rst_data");
        @(negedge HCLK);
        HRESETn = 1'b1;
        wait_cfg = 0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge HCLK);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst_data:no_rsp", 64'(seen), 64'd0);

        // Timeout in address phase (HREADY stuck low)
        stuck = 1'b1;
        xfer("tmo_addr", 32'h0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1'b1, 17, 0);
        chk("tmo_addr:htrans_c1", 64'(ht1), 64'(NONSEQ));
        stuck = 1'b0;

        // Normal operation after the aborts
        xfer("rd100_end", 32'h100, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
